// File: rtl/regfile_bypass_dreg.sv
// Register file with two bypassed read ports, prioritised E/M write ports and an
// integrated decode/execute pipeline register. Optional debug port: REGFILE_DEBUG_PORT_EN.
module regfile_bypass_dreg #(
    parameter int                 DATA_W   = 64,
    parameter int                 ADDR_W   = 4,
    parameter logic [ADDR_W-1:0]  NONE_ID  = {ADDR_W{1'b1}},
    parameter logic [ADDR_W-1:0]  SP_ID    = ADDR_W'(4),
    parameter logic [DATA_W-1:0]  SP_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              stall,
    input  logic              bubble,
    output logic [DATA_W-1:0] valA_q,
    output logic [DATA_W-1:0] valB_q,
    output logic [ADDR_W-1:0] srcA_q,
    output logic [ADDR_W-1:0] srcB_q,
    output logic              valid_q
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] dbg_idx,
    output logic [DATA_W-1:0] dbg_val
`endif
);

    localparam int NREGS = int'(NONE_ID);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Bypassed read: M beats E beats the stored value, matching write priority.
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] x);
        logic [DATA_W-1:0] v;
        v = '0;
        if (x == NONE_ID)   v = '0;
        else if (x == dstM) v = valM;
        else if (x == dstE) v = valE;
        else                v = regs[x];
        return v;
    endfunction

    // NOTE: the combinational result gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        rd_a = rd(srcA);
        rd_b = rd(srcB);
    end

    // NOTE: the register array is reset explicitly because SP must come up at SP_RESET, not just X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (ADDR_W'(i) == SP_ID) ? SP_RESET : '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (ADDR_W'(i) == dstM)      regs[i] <= valM;
                else if (ADDR_W'(i) == dstE) regs[i] <= valE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valA_q  <= '0;
            valB_q  <= '0;
            srcA_q  <= NONE_ID;
            srcB_q  <= NONE_ID;
            valid_q <= 1'b0;
        end else if (stall) begin
            valA_q  <= valA_q;
            valB_q  <= valB_q;
            srcA_q  <= srcA_q;
            srcB_q  <= srcB_q;
            valid_q <= valid_q;
        end else if (bubble) begin
            valA_q  <= '0;
            valB_q  <= '0;
            srcA_q  <= NONE_ID;
            srcB_q  <= NONE_ID;
            valid_q <= 1'b0;
        end else begin
            valA_q  <= rd_a;
            valB_q  <= rd_b;
            srcA_q  <= srcA;
            srcB_q  <= srcB;
            valid_q <= 1'b1;
        end
    end

`ifdef REGFILE_DEBUG_PORT_EN
    // Raw stored contents, deliberately bypass-free.
    always_comb begin
        dbg_val = '0;
        if (dbg_idx != NONE_ID)
            dbg_val = regs[dbg_idx];
    end
`endif

endmodule

// File: tb/tb_regfile_bypass_dreg.sv
// Scoreboard bench for regfile_bypass_dreg: stimulus pushes expected pipeline-register
// contents, a monitor pops and compares them after each clock edge.
module tb_regfile_bypass_dreg;

    typedef struct {
        logic [63:0] va;
        logic [63:0] vb;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic        v;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valE, valM;
    logic        stall, bubble;
    logic [63:0] valA_q, valB_q;
    logic [3:0]  srcA_q, srcB_q;
    logic        valid_q;

    exp_t        exp_q[$];
    logic [63:0] exp_regs [15];
    int          errors = 0;
    int          checks = 0;
    int          step_id = 0;

    regfile_bypass_dreg #(
        .DATA_W(64), .ADDR_W(4), .NONE_ID(4'hF), .SP_ID(4'd4), .SP_RESET(64'h100)
    ) dut (
        .clk(clk), .rst(rst),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .valE(valE), .valM(valM), .stall(stall), .bubble(bubble),
        .valA_q(valA_q), .valB_q(valB_q), .srcA_q(srcA_q), .srcB_q(srcB_q),
        .valid_q(valid_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and record what *_q must hold after the coming edge.
    task automatic step(input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm,
                        input logic st, input logic bu,
                        input logic [63:0] ea, input logic [63:0] eb,
                        input logic [3:0] esa, input logic [3:0] esb, input logic ev);
        exp_t e;
        @(negedge clk);
        srcA = sa; srcB = sb; dstE = de; valE = ve; dstM = dm; valM = vm;
        stall = st; bubble = bu;
        e.va = ea; e.vb = eb; e.sa = esa; e.sb = esb; e.v = ev; e.id = step_id;
        step_id++;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic check_reset_q(input string tag);
        check({tag, " valA_q"},  valA_q,  64'h0);
        check({tag, " valB_q"},  valB_q,  64'h0);
        check({tag, " srcA_q"},  {60'h0, srcA_q}, 64'hF);
        check({tag, " srcB_q"},  {60'h0, srcB_q}, 64'hF);
        check({tag, " valid_q"}, {63'h0, valid_q}, 64'h0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("step%0d valA_q", e.id),  valA_q, e.va);
            check($sformatf("step%0d valB_q", e.id),  valB_q, e.vb);
            check($sformatf("step%0d srcA_q", e.id),  {60'h0, srcA_q}, {60'h0, e.sa});
            check($sformatf("step%0d srcB_q", e.id),  {60'h0, srcB_q}, {60'h0, e.sb});
            check($sformatf("step%0d valid_q", e.id), {63'h0, valid_q}, {63'h0, e.v});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        srcA = 4'hF; srcB = 4'hF; dstE = 4'hF; dstM = 4'hF;
        valE = '0; valM = '0; stall = 1'b0; bubble = 1'b0;
        for (int i = 0; i < 15; i++) exp_regs[i] = 64'h0;
        exp_regs[4] = 64'h100;

        #2;
        check_reset_q("por");
        @(posedge clk);
        #3 rst = 1'b0;

        // Write-through on port E, then the stored copy after the write port idles.
        step(4'd3, 4'd4, 4'd3, 64'hDEAD, 4'hF, 64'h0, 0, 0, 64'hDEAD, 64'h100, 4'd3, 4'd4, 1);
        exp_regs[3] = 64'hDEAD;
        step(4'd3, 4'd0, 4'hF, 64'h0, 4'hF, 64'h0, 0, 0, 64'hDEAD, 64'h0, 4'd3, 4'd0, 1);

        // E/M collision on reg 4: M wins both on the bypass and in storage.
        step(4'hF, 4'd4, 4'd4, 64'h10, 4'd4, 64'h20, 0, 0, 64'h0, 64'h20, 4'hF, 4'd4, 1);
        exp_regs[4] = 64'h20;
        step(4'd4, 4'hF, 4'hF, 64'h55, 4'hF, 64'h0, 0, 0, 64'h20, 64'h0, 4'd4, 4'hF, 1);

        // NONE_ID as destination and source: nothing stored, reads are zero.
        step(4'hF, 4'hF, 4'hF, 64'h55, 4'hF, 64'h77, 0, 0, 64'h0, 64'h0, 4'hF, 4'hF, 1);
        for (int i = 0; i < 15; i += 2)
            step(4'(i), 4'(i + 1), 4'hF, 64'h0, 4'hF, 64'h0, 0, 0,
                 exp_regs[i], (i + 1 < 15) ? exp_regs[i + 1] : 64'h0,
                 4'(i), 4'(i + 1), 1);

        // Stall holds *_q while the register write still lands; bubble inserts a NOP.
        step(4'd1, 4'hF, 4'd1, 64'h7, 4'hF, 64'h0, 0, 0, 64'h7, 64'h0, 4'd1, 4'hF, 1);
        step(4'd1, 4'hF, 4'd1, 64'h9, 4'hF, 64'h0, 1, 0, 64'h7, 64'h0, 4'd1, 4'hF, 1);
        step(4'd1, 4'hF, 4'hF, 64'h0, 4'hF, 64'h0, 0, 0, 64'h9, 64'h0, 4'd1, 4'hF, 1);
        step(4'd2, 4'd3, 4'hF, 64'h0, 4'hF, 64'h0, 1, 1, 64'h9, 64'h0, 4'd1, 4'hF, 1);
        step(4'd2, 4'd3, 4'hF, 64'h0, 4'hF, 64'h0, 0, 1, 64'h0, 64'h0, 4'hF, 4'hF, 0);
        step(4'd2, 4'd3, 4'hF, 64'h0, 4'hF, 64'h0, 0, 0, 64'h0, 64'hDEAD, 4'd2, 4'd3, 1);

        // Asynchronous reset between edges, with a write attempted during reset.
        #3;
        rst = 1'b1; dstE = 4'd4; valE = 64'h77; dstM = 4'd3; valM = 64'h66;
        #1;
        check_reset_q("async");
        @(posedge clk);
        #3 rst = 1'b0; dstE = 4'hF; dstM = 4'hF;
        #1;
        check_reset_q("post-rst");

        step(4'd4, 4'd0, 4'hF, 64'h0, 4'hF, 64'h0, 0, 0, 64'h100, 64'h0, 4'd4, 4'd0, 1);
        step(4'd3, 4'd1, 4'hF, 64'h0, 4'hF, 64'h0, 0, 0, 64'h0, 64'h0, 4'd3, 4'd1, 1);

        #3;
        check("scoreboard drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
